// File: rtl/seq_pkg.sv
// Shared types for the multicycle sequencer: FSM state encoding, opcode constants, legality check.
package seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_CUSTOM = 7'b0001011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic is_legal_op(input logic [6:0] opc);
      case (opc)
         OP_ALU, OP_ALUI, OP_CUSTOM, OP_LOAD, OP_STORE,
         OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal_op = 1'b1;
         default:                                       is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive memory wait cycles; o_expire flags the LIMIT-th one in the same cycle.
// Any cycle without a wait (ready seen or request gone) clears the count.
module seq_wait_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_wait,
   output logic o_expire
);
   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_cnt;

   assign o_expire = i_wait && (r_cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_wait && !o_expire) begin
         r_cnt <= r_cnt + W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/exec/mem/wb control FSM; memory phases hold until mem_ready (3-5 cycles + waits).
// Define SEQ_TIMEOUT_EN to bound memory waits at TIMEOUT_CYCLES and trap with bus_err.
module multicycle_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic               dec_reg_write,
   input  logic               dec_mem_write,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_addr_sel,
   output logic               ir_we,
   output logic               pc_we,
   output logic               rf_we,
   output logic [STATE_W-1:0] state,
   output logic               illegal,
   output logic               bus_err,
   output logic [CNT_W-1:0]   instret
);
   state_e           r_state;
   state_e           w_next;
   logic             w_mem_req;
   logic             w_mem_we;
   logic             w_addr_sel;
   logic             w_ir_we;
   logic             w_pc_we;
   logic             w_rf_we;
   logic             w_ill_set;
   logic             w_expire;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instret;

`ifdef SEQ_TIMEOUT_EN
   logic w_wait;
   logic r_bus_err;

   assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

   seq_wait_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wait   (w_wait),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_err <= 1'b0;
      end else if (w_expire) begin
         r_bus_err <= 1'b1;
      end
   end

   assign bus_err = r_bus_err;
`else
   assign w_expire = 1'b0;
   assign bus_err  = 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_addr_sel = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_rf_we    = 1'b0;
      w_ill_set  = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_we = 1'b1;
               w_next  = ST_DECODE;
            end else if (w_expire) begin
               w_next = ST_TRAP;
            end
         end
         ST_DECODE: begin
            if (is_legal_op(op)) begin
               w_next = ST_EXEC;
            end else begin
               w_next    = ST_TRAP;
               w_ill_set = 1'b1;
            end
         end
         ST_EXEC: begin
            if ((op == OP_LOAD) || (op == OP_STORE)) begin
               w_next = ST_MEM;
            end else if (op == OP_BRANCH) begin
               w_pc_we = 1'b1;
               w_next  = ST_FETCH;
            end else begin
               w_next = ST_WB;
            end
         end
         ST_MEM: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = dec_mem_write;
            if (mem_ready) begin
               if (op == OP_LOAD) begin
                  w_next = ST_WB;
               end else begin
                  w_pc_we = 1'b1;
                  w_next  = ST_FETCH;
               end
            end else if (w_expire) begin
               w_next = ST_TRAP;
            end
         end
         ST_WB: begin
            w_rf_we = dec_reg_write;
            w_pc_we = 1'b1;
            w_next  = ST_FETCH;
         end
         ST_TRAP: begin
            w_next = ST_TRAP;
         end
         default: begin
            w_next = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FETCH;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_ill_set) begin
            r_illegal <= 1'b1;
         end
         if (w_pc_we) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // Strobes are gated by rst_n so they drop the instant reset asserts, not at the next edge.
   assign mem_req      = w_mem_req  & rst_n;
   assign mem_we       = w_mem_we   & rst_n;
   assign mem_addr_sel = w_addr_sel & rst_n;
   assign ir_we        = w_ir_we    & rst_n;
   assign pc_we        = w_pc_we    & rst_n;
   assign rf_we        = w_rf_we    & rst_n;
   assign state        = r_state;
   assign illegal      = r_illegal;
   assign instret      = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomised instruction stream checked cycle-by-cycle against a per-instruction expected schedule.
module tb_multicycle_sequencer;
   localparam int CW  = 4;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    op = 7'd0;
   logic          dec_reg_write = 1'b0;
   logic          dec_mem_write = 1'b0;
   logic          mem_ready = 1'b0;
   logic          mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, illegal, bus_err;
   logic [2:0]    state;
   logic [CW-1:0] instret;

   int total = 0;
   int bad   = 0;
   int m_instret = 0;
   bit m_illegal = 1'b0;

   always #5 clk = ~clk;

   multicycle_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .dec_reg_write(dec_reg_write),
      .dec_mem_write(dec_mem_write), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .rf_we(rf_we), .state(state), .illegal(illegal), .bus_err(bus_err), .instret(instret)
   );

   typedef struct {
      logic [2:0] st;
      bit req, we, sel, ir, pc, rf, rdy, ill;
   } cyc_t;

   cyc_t       tr[$];
   logic [2:0] obs_st[$];
   logic [6:0] legal_ops[10] = '{7'b0110011, 7'b0010011, 7'b0001011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push(logic [2:0] st, bit req, bit we, bit sel, bit ir, bit pc,
                                bit rf, bit rdy, bit ill = 1'b0);
      cyc_t c;
      c.st = st; c.req = req; c.we = we; c.sel = sel; c.ir = ir;
      c.pc = pc; c.rf = rf; c.rdy = rdy; c.ill = ill;
      tr.push_back(c);
   endfunction

   function automatic bit rnd();
      return bit'($urandom_range(0, 1));
   endfunction

   // Expected per-cycle schedule of one instruction, straight from the phase rules.
   function automatic void build(logic [6:0] o, bit rw, bit mw, int fw, int mwt);
      bit legal = 1'b0;
      bit is_ld = (o == 7'b0000011);
      bit is_st = (o == 7'b0100011);
      foreach (legal_ops[k]) if (legal_ops[k] == o) legal = 1'b1;
      for (int i = 0; i < fw; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 0);
      push(3'd0, 1, 0, 0, 1, 0, 0, 1);
      if (!legal) begin
         push(3'd1, 0, 0, 0, 0, 0, 0, rnd(), 1'b1);
         for (int i = 0; i < 3; i++) push(3'd5, 0, 0, 0, 0, 0, 0, rnd());
         return;
      end
      push(3'd1, 0, 0, 0, 0, 0, 0, rnd());
      if (o == 7'b1100011) begin
         push(3'd2, 0, 0, 0, 0, 1, 0, rnd());
         return;
      end
      push(3'd2, 0, 0, 0, 0, 0, 0, rnd());
      if (is_ld || is_st) begin
         for (int i = 0; i < mwt; i++) push(3'd3, 1, mw, 1, 0, 0, 0, 0);
         push(3'd3, 1, mw, 1, 0, is_st, 0, 1);
         if (is_st) return;
      end
      push(3'd4, 0, 0, 0, 0, 1, rw, rnd());
   endfunction

   function automatic void check_cycle(cyc_t e);
      chk("state", 32'(state), 32'(e.st));
      chk("mem_req", 32'(mem_req), 32'(e.req));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_addr_sel", 32'(mem_addr_sel), 32'(e.sel));
      chk("ir_we", 32'(ir_we), 32'(e.ir));
      chk("pc_we", 32'(pc_we), 32'(e.pc));
      chk("rf_we", 32'(rf_we), 32'(e.rf));
      chk("illegal", 32'(illegal), 32'(m_illegal));
      chk("bus_err", 32'(bus_err), 32'd0);
      chk("instret", 32'(instret), 32'(m_instret));
   endfunction

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_ir_we", 32'(ir_we), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      m_instret = 0;
      m_illegal = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_hold_pc_we", 32'(pc_we), 32'd0);
      chk("rst_hold_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Drives one instruction; lat counts cycles up to and including the pc_we cycle.
   task automatic run_instr(input logic [6:0] o, input bit rw, input bit mw, input int fw,
                            input int mwt, input int abort_at, output int lat);
      bit seen = 1'b0;
      tr.delete();
      obs_st.delete();
      build(o, rw, mw, fw, mwt);
      op = o; dec_reg_write = rw; dec_mem_write = mw;
      lat = 0;
      for (int i = 0; i < tr.size(); i++) begin
         mem_ready = tr[i].rdy;
         @(negedge clk);
         check_cycle(tr[i]);
         obs_st.push_back(state);
         if (!seen) lat++;
         if (tr[i].pc) seen = 1'b1;
         if (i == abort_at) begin
            do_reset();
            return;
         end
         @(posedge clk); #1;
         if (tr[i].pc) m_instret = (m_instret + 1) % (1 << CW);
         if (tr[i].ill) m_illegal = 1'b1;
      end
   endtask

   initial begin
      int lat;
      logic [2:0] exp_seq[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
      #3;
      chk("init_state", 32'(state), 32'd0);
      chk("init_mem_req", 32'(mem_req), 32'd0);
      chk("init_instret", 32'(instret), 32'd0);
      chk("init_illegal", 32'(illegal), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_instr(7'b0110011, 1, 0, 0, 0, -1, lat);
      chk("alu_latency", 32'(lat), 32'd4);
      chk("alu_seq_len", 32'(obs_st.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_st.size(); i++) chk("alu_seq", 32'(obs_st[i]), 32'(exp_seq[i]));
      chk("alu_back_to_fetch", 32'(state), 32'd0);
      chk("alu_instret", 32'(instret), 32'd1);

      run_instr(7'b0000011, 1, 0, 0, 3, -1, lat);
      chk("load_wait3_latency", 32'(lat), 32'd8);
      run_instr(7'b0000011, 1, 0, 0, 0, -1, lat);
      chk("load_latency", 32'(lat), 32'd5);
      run_instr(7'b0100011, 0, 1, 0, 0, -1, lat);
      chk("store_latency", 32'(lat), 32'd4);
      run_instr(7'b1100011, 1, 0, 0, 0, -1, lat);
      chk("branch_latency", 32'(lat), 32'd3);
      chk("instret_after5", 32'(instret), 32'd5);

      for (int n = 0; n < 300; n++) begin
         logic [6:0] o;
         if ($urandom_range(0, 9) == 0) o = 7'($urandom);
         else o = legal_ops[$urandom_range(0, 9)];
         run_instr(o, rnd(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3), -1, lat);
         if (m_illegal) do_reset();
      end

      do_reset();
      for (int n = 0; n < 15; n++) run_instr(7'b0010011, rnd(), 0, 0, 0, -1, lat);
      chk("instret_all_ones", 32'(instret), 32'hF);
      run_instr(7'b1101111, 1, 0, 1, 0, -1, lat);
      chk("instret_wrap", 32'(instret), 32'd0);

      run_instr(7'b1111111, 1, 1, 0, 0, -1, lat);
      chk("trap_state", 32'(state), 32'd5);
      chk("trap_illegal", 32'(illegal), 32'd1);
      do_reset();
      chk("post_trap_illegal", 32'(illegal), 32'd0);
      chk("post_trap_state", 32'(state), 32'd0);

      run_instr(7'b0110111, 1, 0, 0, 0, -1, lat);
      run_instr(7'b0000011, 1, 0, 0, 3, 4, lat);
      chk("abort_instret", 32'(instret), 32'd0);
      run_instr(7'b0110011, 1, 0, 2, 0, -1, lat);
      chk("after_abort_latency", 32'(lat), 32'd6);

`ifdef SEQ_TIMEOUT_EN
      begin
         int nreq = 0;
         mem_ready = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) nreq++;
         end
         chk("tmo_req_cycles", 32'(nreq), 32'(TMO));
         chk("tmo_state", 32'(state), 32'd5);
         chk("tmo_bus_err", 32'(bus_err), 32'd1);
         @(posedge clk); #1;
         #2 rst_n = 1'b0;
         #1 chk("tmo_rst_bus_err", 32'(bus_err), 32'd0);
         @(negedge clk) rst_n = 1'b1;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
